// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer: reads two operands over one sync RF port, drives the alu, writes back result and flags.
// Latency: start -> WB in 5 cycles, one instruction per 6 cycles; no backpressure, start is ignored while busy.
module alu_exec_ctrl #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int OP_W   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [OP_W-1:0]   op_in,
    input  logic [REG_AW-1:0] rs_a,
    input  logic [REG_AW-1:0] rs_b,
    input  logic [REG_AW-1:0] rd,
    output logic              busy,
    output logic              done,
    output logic [REG_AW-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [DATA_W-1:0] tmp1,
    output logic [DATA_W-1:0] tmp2,
    output logic [OP_W-1:0]   op,
    output logic              enable,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_carry,
    output logic              zero_flag,
    output logic              carry_flag
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RDA  = 3'd1,
        S_RDB  = 3'd2,
        S_LDB  = 3'd3,
        S_EXEC = 3'd4,
        S_WB   = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [REG_AW-1:0]   rs_a_q, rs_a_d, rs_b_q, rs_b_d, rd_q, rd_d;
    logic [DATA_W-1:0]   tmp1_q, tmp1_d, tmp2_q, tmp2_d;
    logic [OP_W-1:0]     alu_op_q, alu_op_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                zero_q, zero_d, carry_q, carry_d;
    logic                busy_q, busy_d, done_q, done_d, enable_q, enable_d;
    logic                rf_we_q, rf_we_d;
    logic [REG_AW-1:0]   rf_raddr_q, rf_raddr_d, rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rs_a_d   = rs_a_q;
        rs_b_d   = rs_b_q;
        rd_d     = rd_q;
        tmp1_d   = tmp1_q;
        tmp2_d   = tmp2_q;
        alu_op_d = alu_op_q;
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op_in;
                    rs_a_d  = rs_a;
                    rs_b_d  = rs_b;
                    rd_d    = rd;
                    state_d = S_RDA;
                end
            end
            S_RDA:  state_d = S_RDB;
            S_RDB: begin
                // r0 is hard-wired to zero whatever the register file returns
                tmp1_d  = (rs_a_q == '0) ? '0 : rf_rdata;
                state_d = S_LDB;
            end
            S_LDB: begin
                tmp2_d   = (rs_b_q == '0) ? '0 : rf_rdata;
                alu_op_d = op_q;
                state_d  = S_EXEC;
            end
            S_EXEC: begin
                result_d = alu_result;
                zero_d   = alu_zero;
                carry_d  = alu_carry;
                state_d  = S_WB;
            end
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Control outputs are decoded from the next state so they come straight off flops
        busy_d     = (state_d != S_IDLE);
        enable_d   = (state_d == S_EXEC);
        done_d     = (state_d == S_WB);
        rf_we_d    = (state_d == S_WB) && (rd_d != '0);
        rf_waddr_d = (state_d == S_WB) ? rd_d : '0;
        rf_wdata_d = (state_d == S_WB) ? result_d : '0;
        rf_raddr_d = (state_d == S_RDA) ? rs_a_d :
                     (state_d == S_RDB) ? rs_b_d : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            rs_a_q     <= '0;
            rs_b_q     <= '0;
            rd_q       <= '0;
            tmp1_q     <= '0;
            tmp2_q     <= '0;
            alu_op_q   <= '0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            enable_q   <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_raddr_q <= '0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            rs_a_q     <= rs_a_d;
            rs_b_q     <= rs_b_d;
            rd_q       <= rd_d;
            tmp1_q     <= tmp1_d;
            tmp2_q     <= tmp2_d;
            alu_op_q   <= alu_op_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            carry_q    <= carry_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            enable_q   <= enable_d;
            rf_we_q    <= rf_we_d;
            rf_raddr_q <= rf_raddr_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign enable     = enable_q;
    assign rf_we      = rf_we_q;
    assign rf_raddr   = rf_raddr_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign tmp1       = tmp1_q;
    assign tmp2       = tmp2_q;
    assign op         = alu_op_q;
    assign zero_flag  = zero_q;
    assign carry_flag = carry_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: behavioural register file and alu around the DUT, architectural reference model.
module tb_alu_exec_ctrl;
    localparam int DW = 16;
    localparam int AW = 4;
    localparam int OW = 3;

    logic          clk = 1'b0;
    logic          reset, start;
    logic [OW-1:0] op_in;
    logic [AW-1:0] rs_a, rs_b, rd;
    logic          busy, done, rf_we, enable, zero_flag, carry_flag;
    logic [AW-1:0] rf_raddr, rf_waddr;
    logic [DW-1:0] rf_rdata, rf_wdata, tmp1, tmp2, alu_result;
    logic [OW-1:0] op;
    logic          alu_zero, alu_carry;

    logic [DW-1:0] mem [16];
    logic [DW-1:0] ref_regs [16];
    logic          pl_we = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_dat = '0;
    int            wr_count = 0;
    int            n_checks = 0;
    int            n_pass = 0;

    always #5 clk = ~clk;

    alu_exec_ctrl #(.DATA_W(DW), .REG_AW(AW), .OP_W(OW)) dut (
        .clk(clk), .reset(reset), .start(start), .op_in(op_in),
        .rs_a(rs_a), .rs_b(rs_b), .rd(rd), .busy(busy), .done(done),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .tmp1(tmp1), .tmp2(tmp2),
        .op(op), .enable(enable), .alu_result(alu_result), .alu_zero(alu_zero),
        .alu_carry(alu_carry), .zero_flag(zero_flag), .carry_flag(carry_flag)
    );

    // Returns {zero, carry, result[15:0]}
    function automatic logic [17:0] alu_f(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] w;
        case (o)
            3'd0:    w = {1'b0, a} + {1'b0, b};
            3'd1:    w = {1'b0, a} - {1'b0, b};
            3'd2:    w = {1'b0, a & b};
            3'd3:    w = {1'b0, a | b};
            3'd4:    w = {1'b0, a ^ b};
            3'd5:    w = {a, 1'b0};
            3'd6:    w = {a[0], 1'b0, a[15:1]};
            default: w = {1'b0, a};
        endcase
        return {(w[15:0] == 16'h0000), w[16], w[15:0]};
    endfunction

    assign {alu_zero, alu_carry, alu_result} = alu_f(op, tmp1, tmp2);

    // Register file with a one-cycle synchronous read port; r0 holds a non-zero sentinel
    always @(posedge clk) begin
        rf_rdata <= mem[rf_raddr];
        if (rf_we) begin
            mem[rf_waddr] <= rf_wdata;
            wr_count      <= wr_count + 1;
        end else if (pl_we) begin
            mem[pl_addr] <= pl_dat;
        end
    end

    task automatic preload(input logic [3:0] r, input logic [15:0] v);
        pl_we = 1'b1; pl_addr = r; pl_dat = v;
        @(negedge clk);
        pl_we = 1'b0;
        ref_regs[r] = (r == 4'd0) ? 16'h0000 : v;
    endtask

    // Issues one instruction from an IDLE negedge and returns at the negedge of the following IDLE cycle.
    // noise: 0 quiet, 1 start held high while busy, 2 random start while busy.
    task automatic exec_instr(input logic [2:0] o, input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] d, input int noise);
        logic [15:0] ea, eb, exp_mem;
        logic [17:0] e;
        logic [7:0]  exp_ctl;
        int          w0;
        ea = ref_regs[a];
        eb = ref_regs[b];
        e  = alu_f(o, ea, eb);
        w0 = wr_count;
        op_in = o; rs_a = a; rs_b = b; rd = d; start = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            exp_ctl = {1'b1, (k == 4), (k == 5), (k == 5) && (d != 4'd0),
                       (k == 1) ? a : (k == 2) ? b : 4'd0};
            n_checks++;
            if ({busy, enable, done, rf_we, rf_raddr} !== exp_ctl)
                $display("FAIL ctl k=%0d got %b exp %b", k, {busy, enable, done, rf_we, rf_raddr}, exp_ctl);
            else n_pass++;
            if (k == 4) begin
                n_checks++;
                if ({tmp1, tmp2, op} !== {ea, eb, o})
                    $display("FAIL operands got %h %h %0d exp %h %h %0d", tmp1, tmp2, op, ea, eb, o);
                else n_pass++;
            end
            if (k == 5) begin
                n_checks++;
                if ({rf_waddr, rf_wdata} !== {d, e[15:0]})
                    $display("FAIL wb got addr %0d data %h exp addr %0d data %h", rf_waddr, rf_wdata, d, e[15:0]);
                else n_pass++;
            end
            start = (noise == 1) ? 1'b1 : (noise == 2) ? 1'($urandom) : 1'b0;
            op_in = 3'($urandom); rs_a = 4'($urandom); rs_b = 4'($urandom); rd = 4'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if ({busy, done, enable, rf_we, zero_flag, carry_flag} !== {4'b0000, e[17], e[16]})
            $display("FAIL idle_flags got %b exp %b", {busy, done, enable, rf_we, zero_flag, carry_flag},
                     {4'b0000, e[17], e[16]});
        else n_pass++;
        if (d != 4'd0) ref_regs[d] = e[15:0];
        exp_mem = (d != 4'd0) ? e[15:0] : 16'hDEAD;
        n_checks++;
        if ((wr_count - w0) != ((d != 4'd0) ? 1 : 0) || mem[d] !== exp_mem)
            $display("FAIL write got %0d writes r%0d=%h exp %0d writes r%0d=%h",
                     wr_count - w0, d, mem[d], (d != 4'd0) ? 1 : 0, d, exp_mem);
        else n_pass++;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; op_in = '0; rs_a = '0; rs_b = '0; rd = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, enable, rf_we, rf_raddr, rf_waddr, rf_wdata, tmp1, tmp2, op, zero_flag, carry_flag} !== 65'd0)
            $display("FAIL reset got %h exp 0",
                     {busy, done, enable, rf_we, rf_raddr, rf_waddr, rf_wdata, tmp1, tmp2, op, zero_flag, carry_flag});
        else n_pass++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add_carry;
        preload(4'd1, 16'hFFFF);
        preload(4'd2, 16'hFFFE);
        exec_instr(3'd0, 4'd1, 4'd2, 4'd3, 0);
    endtask

    task automatic test_wrap;
        preload(4'd1, 16'h7FFF);
        preload(4'd2, 16'h0002);
        exec_instr(3'd0, 4'd1, 4'd2, 4'd4, 0);
    endtask

    task automatic test_r0;
        preload(4'd5, 16'h0003);
        exec_instr(3'd0, 4'd0, 4'd5, 4'd0, 0);
        exec_instr(3'd1, 4'd5, 4'd0, 4'd9, 0);
        exec_instr(3'd0, 4'd2, 4'd2, 4'd11, 0);
    endtask

    task automatic test_ignore_start;
        exec_instr(3'd4, 4'd1, 4'd5, 4'd10, 1);
    endtask

    task automatic test_back_to_back;
        exec_instr(3'd1, 4'd2, 4'd1, 4'd12, 1);
        exec_instr(3'd3, 4'd12, 4'd5, 4'd13, 1);
        exec_instr(3'd6, 4'd13, 4'd0, 4'd14, 0);
    endtask

    task automatic test_zero;
        preload(4'd6, 16'h0000);
        preload(4'd7, 16'h0000);
        exec_instr(3'd0, 4'd6, 4'd7, 4'd8, 0);
    endtask

    task automatic test_reset_mid;
        int w0;
        exec_instr(3'd0, 4'd1, 4'd1, 4'd15, 0);
        w0 = wr_count;
        op_in = 3'd0; rs_a = 4'd1; rs_b = 4'd2; rd = 4'd12; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (enable !== 1'b1) $display("FAIL reset_mid_exec got enable %b exp 1", enable);
        else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if ({busy, done, enable, rf_we, rf_raddr, rf_waddr, rf_wdata, tmp1, tmp2, op, zero_flag, carry_flag} !== 65'd0)
            $display("FAIL reset_mid got %h exp 0",
                     {busy, done, enable, rf_we, rf_raddr, rf_waddr, rf_wdata, tmp1, tmp2, op, zero_flag, carry_flag});
        else n_pass++;
        repeat (4) @(negedge clk);
        n_checks++;
        if (wr_count != w0 || busy !== 1'b0)
            $display("FAIL reset_mid_nowrite got %0d writes busy %b exp 0 writes busy 0", wr_count - w0, busy);
        else n_pass++;
    endtask

    task automatic test_random;
        for (int r = 1; r < 16; r++) preload(4'(r), 16'($urandom));
        for (int i = 0; i < 40; i++)
            exec_instr(3'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 2);
    endtask

    initial begin
        for (int r = 0; r < 16; r++) ref_regs[r] = 16'h0000;
        reset = 1'b1; start = 1'b0;
        @(negedge clk);
        test_reset;
        preload(4'd0, 16'hDEAD);
        for (int r = 1; r < 16; r++) preload(4'(r), 16'h0000);
        test_add_carry;
        test_wrap;
        test_r0;
        test_ignore_start;
        test_back_to_back;
        test_zero;
        test_reset_mid;
        test_random;
        for (int r = 1; r < 16; r++) begin
            n_checks++;
            if (mem[r] !== ref_regs[r]) $display("FAIL regfile r%0d got %h exp %h", r, mem[r], ref_regs[r]);
            else n_pass++;
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
